serial_frame_router: RTL

- Parametrised next-generation serial frame receiver and demultiplexer.
- Takes one serial input line and parses frames of the form: start bit, address field, length field, turnaround bit, data burst(s).
- Routes each data bit, with a per-channel valid strobe, to one of N_CH logical channels selected by the address.
- Sits between the serial line front end and the per-channel consumers. Adds repeated bursts, address range checking and frame status pulses.

---
 rtl/serial_frame_router.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/serial_frame_router.sv
// Serial frame receiver: start bit, LSB-first address and length, turnaround, then repeatable
// (L+1)-bit bursts routed to the channel named by the address. SFR_PARITY_EN adds burst parity.
module serial_frame_router #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 6,
    parameter int N_CH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              si,
    output logic              data_out,
    output logic [N_CH-1:0]   ch_valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              busy,
    output logic              frame_done,
`ifdef SFR_PARITY_EN
    output logic              par_err,
`endif
    output logic              addr_err
);

    localparam int CNT_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLen,
        StLoad,
        StData,
`ifdef SFR_PARITY_EN
        StPar,
`endif
        StSpacer
    } state_e;

    state_e              r_state;
    logic [CNT_W-1:0]    r_bcnt;
    logic [ADDR_W-1:0]   r_addr_sh;
    logic [LEN_W-1:0]    r_len_sh;
    logic [LEN_W-1:0]    r_dcnt;
`ifdef SFR_PARITY_EN
    logic                r_par;
`endif

    logic [ADDR_W-1:0]   w_addr_next;
    logic [LEN_W-1:0]    w_len_next;
    logic [N_CH-1:0]     w_onehot;
    logic                w_addr_ok;

    // LSB-first shift: each new bit enters at the top and moves down.
    if (ADDR_W > 1) begin : g_addr_sh
        assign w_addr_next = {si, r_addr_sh[ADDR_W-1:1]};
    end else begin : g_addr_bit
        assign w_addr_next = si;
    end

    if (LEN_W > 1) begin : g_len_sh
        assign w_len_next = {si, r_len_sh[LEN_W-1:1]};
    end else begin : g_len_bit
        assign w_len_next = si;
    end

    // Out-of-range addresses match no channel, so ch_valid stays zero for them.
    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (addr_out == ADDR_W'(k)) begin
                w_onehot[k] = 1'b1;
            end
        end
    end

    assign w_addr_ok = ({1'b0, addr_out} < (ADDR_W + 1)'(N_CH));
    assign busy      = (r_state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_bcnt     <= '0;
            r_addr_sh  <= '0;
            r_len_sh   <= '0;
            r_dcnt     <= '0;
            data_out   <= 1'b0;
            ch_valid   <= '0;
            addr_out   <= '0;
            len_out    <= '0;
            frame_done <= 1'b0;
            addr_err   <= 1'b0;
`ifdef SFR_PARITY_EN
            r_par      <= 1'b0;
            par_err    <= 1'b0;
`endif
        end else begin
            data_out   <= 1'b0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            addr_err   <= 1'b0;
`ifdef SFR_PARITY_EN
            par_err    <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    if (!si) begin
                        r_state <= StAddr;
                        r_bcnt  <= '0;
                    end
                end
                StAddr: begin
                    r_addr_sh <= w_addr_next;
                    if (r_bcnt == ADDR_LAST) begin
                        addr_out <= w_addr_next;
                        r_bcnt   <= '0;
                        r_state  <= StLen;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                StLen: begin
                    r_len_sh <= w_len_next;
                    if (r_bcnt == LEN_LAST) begin
                        r_bcnt   <= '0;
                        r_state  <= StLoad;
                        // Raised on entry so the pulse coincides with the LOAD cycle.
                        addr_err <= !w_addr_ok;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                StLoad: begin
                    len_out <= r_len_sh;
                    r_dcnt  <= r_len_sh;
                    r_state <= StData;
`ifdef SFR_PARITY_EN
                    r_par   <= 1'b0;
`endif
                end
                StData: begin
                    data_out <= si;
                    ch_valid <= w_onehot;
`ifdef SFR_PARITY_EN
                    r_par    <= r_par ^ si;
`endif
                    if (r_dcnt == '0) begin
`ifdef SFR_PARITY_EN
                        r_state <= StPar;
`else
                        r_state <= StSpacer;
`endif
                    end else begin
                        r_dcnt <= r_dcnt - 1'b1;
                    end
                end
`ifdef SFR_PARITY_EN
                StPar: begin
                    par_err <= (si != r_par);
                    r_state <= StSpacer;
                end
`endif
                StSpacer: begin
                    if (si) begin
                        frame_done <= 1'b1;
                        r_state    <= StIdle;
                    end else begin
                        r_dcnt  <= len_out;
                        r_state <= StData;
`ifdef SFR_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
